// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: default memory geometry,
// the default host starvation limit, the arbiter FSM state encoding and a
// helper that sizes the host wait counter.
// Ports: none (package).
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int DEF_NUBITS = 16;
  localparam int DEF_MDATAS = 64;
  localparam int DEF_STARVE = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } arb_state_e;

  // The wait counter must be able to hold the value 'limit' itself; a limit
  // of zero still needs a one-bit counter so the compare stays legal.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// -----------------------------------------------------------------------------
// dmem_arb_if
// Host-side request/acknowledge bus of the data-memory arbiter.
// Signals:
//   req   host request, held with we/addr/wdata stable until ack
//   we    1 = write, 0 = read
//   addr  host address (MDATAW bits)
//   wdata host write data (NUBITS bits)
//   ack   one-cycle completion pulse from the arbiter
//   rdata read data, valid with ack and held until the next ack
// Modports: master = host side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dmem_arb_if
  import dmem_arb_pkg::*;
#(
  parameter int NUBITS = DEF_NUBITS,
  parameter int MDATAW = $clog2(DEF_MDATAS)
);

  logic              req;
  logic              we;
  logic [MDATAW-1:0] addr;
  logic [NUBITS-1:0] wdata;
  logic              ack;
  logic [NUBITS-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// arb_starve_cnt
// Counts the cycles a host request waits in IDLE without being accepted and
// raises a one-cycle registered stall once the count has reached STARVE.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   host_req_i   host request line
//   idle_i       arbiter FSM is in IDLE
//   accept_i     arbiter accepts the host request this cycle
//   stall_o      registered core stall (one cycle)
// -----------------------------------------------------------------------------
module arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int STARVE = DEF_STARVE
) (
  input  logic clk,
  input  logic rst,
  input  logic host_req_i,
  input  logic idle_i,
  input  logic accept_i,
  output logic stall_o
);

  localparam int            CW    = cnt_width(STARVE);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_q, stall_d;
  logic          waiting;

  // The counter saturates at LIMIT, so the stall is requested on the first
  // waiting cycle at the limit; the stall cycle itself forces acceptance,
  // which clears the counter and keeps the stall to a single cycle.
  always_comb begin
    waiting = idle_i && host_req_i && !accept_i;
    cnt_d   = cnt_q;
    stall_d = waiting && (cnt_q == LIMIT);
    if (!host_req_i || accept_i) begin
      cnt_d = '0;
    end else if (waiting && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_o = stall_q;

endmodule

// File: rtl/dmem_arb.sv
// -----------------------------------------------------------------------------
// dmem_arb
// Shares a one-write/one-read data memory between the core (priority) and a
// host request bus. A starving host forces a one-cycle core stall.
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   core_rd_i, core_addr_rd_i   core read strobe / address
//   core_wr_i, core_addr_wr_i,
//   core_wdata_i                core write strobe / address / data
//   core_rdata_o                memory read data passed through to the core
//   core_stall_o                registered one-cycle core stall
//   host                        host bus (dmem_arb_if.slave)
//   m_wr_o, m_addr_wr_o,
//   m_wdata_o, m_addr_rd_o      memory write port and read address
//   m_rdata_i                   memory read data, one-cycle latency
//   err_col_o                   sticky: core strobe seen during a stall
// -----------------------------------------------------------------------------
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int NUBITS = DEF_NUBITS,
  parameter int MDATAS = DEF_MDATAS,
  parameter int MDATAW = $clog2(MDATAS),
  parameter int STARVE = DEF_STARVE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_rd_i,
  input  logic [MDATAW-1:0] core_addr_rd_i,
  input  logic              core_wr_i,
  input  logic [MDATAW-1:0] core_addr_wr_i,
  input  logic [NUBITS-1:0] core_wdata_i,
  output logic [NUBITS-1:0] core_rdata_o,
  output logic              core_stall_o,
  dmem_arb_if.slave         host,
  output logic              m_wr_o,
  output logic [MDATAW-1:0] m_addr_wr_o,
  output logic [NUBITS-1:0] m_wdata_o,
  output logic [MDATAW-1:0] m_addr_rd_o,
  input  logic [NUBITS-1:0] m_rdata_i,
  output logic              err_col_o
);

  arb_state_e        state_q, state_d;
  logic [NUBITS-1:0] rdata_q;
  logic              err_q;
  logic              stall;
  logic              stall_eff;
  logic              core_wr_en, core_rd_en;
  logic              host_wr_acc, host_rd_acc;

  arb_starve_cnt #(
    .STARVE (STARVE)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .host_req_i (host.req),
    .idle_i     (state_q == IDLE),
    .accept_i   (host_wr_acc | host_rd_acc),
    .stall_o    (stall)
  );

  // During reset the core keeps direct control of the memory ports even if a
  // stall was still registered. Host acceptance is blocked under reset so a
  // pending host access never reaches memory.
  always_comb begin
    stall_eff   = stall && !rst;
    core_wr_en  = core_wr_i && !stall_eff;
    core_rd_en  = core_rd_i && !stall_eff;
    host_wr_acc = 1'b0;
    host_rd_acc = 1'b0;
    state_d     = state_q;
    unique case (state_q)
      IDLE: begin
        if (host.req && !rst) begin
          if (host.we && !core_wr_en) begin
            host_wr_acc = 1'b1;
            state_d     = ACK;
          end else if (!host.we && !core_rd_en) begin
            host_rd_acc = 1'b1;
            state_d     = RD_WAIT;
          end
        end
      end
      RD_WAIT: state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Host access only wins a port when the core is not using it, so the
  // address/data muxes can key off the host acceptance alone.
  always_comb begin
    m_wr_o      = core_wr_en | host_wr_acc;
    m_addr_wr_o = host_wr_acc ? host.addr  : core_addr_wr_i;
    m_wdata_o   = host_wr_acc ? host.wdata : core_wdata_i;
    m_addr_rd_o = host_rd_acc ? host.addr  : core_addr_rd_i;
  end

  // Memory data for an accepted host read is valid during RD_WAIT and is
  // latched at the end of that cycle, ready alongside the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RD_WAIT) begin
        rdata_q <= m_rdata_i;
      end
      if (stall && (core_rd_i || core_wr_i)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign host.ack     = (state_q == ACK);
  assign host.rdata   = rdata_q;
  assign core_rdata_o = m_rdata_i;
  assign core_stall_o = stall;
  assign err_col_o    = err_q;

endmodule

// File: tb/tb_dmem_arb.sv
// -----------------------------------------------------------------------------
// tb_dmem_arb
// Directed bench for dmem_arb with a behavioural one-cycle-latency memory.
// -----------------------------------------------------------------------------
module tb_dmem_arb;

  localparam int NUBITS = 16;
  localparam int MDATAS = 64;
  localparam int MDATAW = 6;
  localparam int STARVE = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              coreRd, coreWr;
  logic [MDATAW-1:0] coreAddrRd, coreAddrWr;
  logic [NUBITS-1:0] coreWdata, coreRdata;
  logic              coreStall;
  logic              mWr;
  logic [MDATAW-1:0] mAddrWr, mAddrRd;
  logic [NUBITS-1:0] mWdata, mRdata;
  logic              errCol;
  logic              loadMem;

  logic [NUBITS-1:0] mem    [MDATAS];
  logic [NUBITS-1:0] expMem [MDATAS];

  int numChecks = 0;
  int numErrors = 0;

  always #5 clk = ~clk;

  dmem_arb_if #(.NUBITS(NUBITS), .MDATAW(MDATAW)) hostBus ();

  dmem_arb #(
    .NUBITS (NUBITS),
    .MDATAS (MDATAS),
    .MDATAW (MDATAW),
    .STARVE (STARVE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .core_rd_i      (coreRd),
    .core_addr_rd_i (coreAddrRd),
    .core_wr_i      (coreWr),
    .core_addr_wr_i (coreAddrWr),
    .core_wdata_i   (coreWdata),
    .core_rdata_o   (coreRdata),
    .core_stall_o   (coreStall),
    .host           (hostBus),
    .m_wr_o         (mWr),
    .m_addr_wr_o    (mAddrWr),
    .m_wdata_o      (mWdata),
    .m_addr_rd_o    (mAddrRd),
    .m_rdata_i      (mRdata),
    .err_col_o      (errCol)
  );

  function automatic logic [NUBITS-1:0] pattern(input int i);
    return 16'(i * 257 + 'h0F00);
  endfunction

  // Behavioural data memory: preload on demand, otherwise one write port and
  // a registered read port.
  always @(posedge clk) begin
    if (loadMem) begin
      for (int i = 0; i < MDATAS; i++) mem[i] <= pattern(i);
    end else if (mWr) begin
      mem[mAddrWr] <= mWdata;
    end
    mRdata <= mem[mAddrRd];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs just after the falling edge and leaves time
  // for combinational outputs to settle before checks.
  task automatic applyStimulus(input int r, input int cRd, input int cAddrRd,
                               input int cWr, input int cAddrWr, input int cWdata,
                               input int hReq, input int hWe, input int hAddr,
                               input int hWdata);
    @(negedge clk);
    rst             = r[0];
    coreRd          = cRd[0];
    coreAddrRd      = 6'(cAddrRd);
    coreWr          = cWr[0];
    coreAddrWr      = 6'(cAddrWr);
    coreWdata       = 16'(cWdata);
    hostBus.req     = hReq[0];
    hostBus.we      = hWe[0];
    hostBus.addr    = 6'(hAddr);
    hostBus.wdata   = 16'(hWdata);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic hostRead(input int a, input logic [NUBITS-1:0] expData,
                          input string tag);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, a, 0);
    checkOutput({tag, " rd addr"}, 32'(mAddrRd), 32'(a));
    checkOutput({tag, " ack A"}, 32'(hostBus.ack), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, a, 0);
    checkOutput({tag, " ack A+1"}, 32'(hostBus.ack), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, a, 0);
    checkOutput({tag, " ack A+2"}, 32'(hostBus.ack), 1);
    checkOutput({tag, " rdata"}, 32'(hostBus.rdata), 32'(expData));
  endtask

  initial begin
    rst = 1'b1; loadMem = 1'b1;
    coreRd = 1'b0; coreWr = 1'b0; coreAddrRd = '0; coreAddrWr = '0; coreWdata = '0;
    hostBus.req = 1'b0; hostBus.we = 1'b0; hostBus.addr = '0; hostBus.wdata = '0;
    for (int i = 0; i < MDATAS; i++) expMem[i] = pattern(i);

    // Reset: memory ports still follow the core
    applyStimulus(1, 1, 7, 1, 1, 'hBEEF, 0, 0, 0, 0);
    checkOutput("rst m_wr", 32'(mWr), 1);
    checkOutput("rst m_addr_wr", 32'(mAddrWr), 1);
    checkOutput("rst m_wdata", 32'(mWdata), 'hBEEF);
    checkOutput("rst m_addr_rd", 32'(mAddrRd), 7);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    loadMem = 1'b0;
    idleCycle();
    checkOutput("rst host_ack", 32'(hostBus.ack), 0);
    checkOutput("rst host_rdata", 32'(hostBus.rdata), 0);
    checkOutput("rst core_stall", 32'(coreStall), 0);
    checkOutput("rst err_col", 32'(errCol), 0);

    // Host write then read with an idle core
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 5, 'h1234);
    checkOutput("hw m_wr", 32'(mWr), 1);
    checkOutput("hw m_addr_wr", 32'(mAddrWr), 5);
    checkOutput("hw m_wdata", 32'(mWdata), 'h1234);
    checkOutput("hw ack A", 32'(hostBus.ack), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 5, 'h1234);
    checkOutput("hw ack A+1", 32'(hostBus.ack), 1);
    checkOutput("hw m_wr A+1", 32'(mWr), 0);
    expMem[5] = 16'h1234;
    idleCycle();
    checkOutput("hw ack after", 32'(hostBus.ack), 0);
    hostRead(5, 16'h1234, "hr5");
    idleCycle();
    checkOutput("hr rdata held", 32'(hostBus.rdata), 'h1234);
    checkOutput("hr ack drop", 32'(hostBus.ack), 0);

    // Same-address collision: core write first, host write next cycle
    applyStimulus(0, 0, 0, 1, 3, 7, 1, 1, 3, 9);
    checkOutput("col m_wr A", 32'(mWr), 1);
    checkOutput("col addr A", 32'(mAddrWr), 3);
    checkOutput("col data A", 32'(mWdata), 7);
    checkOutput("col ack A", 32'(hostBus.ack), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 3, 9);
    checkOutput("col m_wr A+1", 32'(mWr), 1);
    checkOutput("col addr A+1", 32'(mAddrWr), 3);
    checkOutput("col data A+1", 32'(mWdata), 9);
    checkOutput("col ack A+1", 32'(hostBus.ack), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 3, 9);
    checkOutput("col ack A+2", 32'(hostBus.ack), 1);
    expMem[3] = 16'h0009;
    idleCycle();
    hostRead(3, 16'h0009, "col rd3");
    idleCycle();

    // Starvation: core reads continuously, obeys the stall
    for (int k = 0; k < 13; k++) begin
      applyStimulus(0, (k != 9) ? 1 : 0, 10, 0, 0, 0, (k <= 11) ? 1 : 0, 0, 5, 0);
      checkOutput($sformatf("starve stall k%0d", k), 32'(coreStall), (k == 9) ? 1 : 0);
      checkOutput($sformatf("starve ack k%0d", k), 32'(hostBus.ack), (k == 11) ? 1 : 0);
      checkOutput($sformatf("starve rdaddr k%0d", k), 32'(mAddrRd), (k == 9) ? 5 : 10);
      if (k == 11) checkOutput("starve rdata", 32'(hostBus.rdata), 'h1234);
    end
    checkOutput("starve err_col", 32'(errCol), 0);
    idleCycle();

    // Starvation with a core that keeps writing through the stall
    for (int k = 0; k < 13; k++) begin
      applyStimulus(0, 0, 0, 1, 20, 'h00AA, (k <= 10) ? 1 : 0, 1, 21, 'h0BBB);
      checkOutput($sformatf("viol stall k%0d", k), 32'(coreStall), (k == 9) ? 1 : 0);
      checkOutput($sformatf("viol m_wr k%0d", k), 32'(mWr), 1);
      checkOutput($sformatf("viol waddr k%0d", k), 32'(mAddrWr), (k == 9) ? 21 : 20);
      checkOutput($sformatf("viol wdata k%0d", k), 32'(mWdata), (k == 9) ? 'h0BBB : 'h00AA);
      checkOutput($sformatf("viol ack k%0d", k), 32'(hostBus.ack), (k == 10) ? 1 : 0);
      checkOutput($sformatf("viol err k%0d", k), 32'(errCol), (k >= 10) ? 1 : 0);
    end
    expMem[20] = 16'h00AA;
    expMem[21] = 16'h0BBB;
    idleCycle();
    hostRead(21, 16'h0BBB, "viol rd21");
    idleCycle();
    checkOutput("err sticky", 32'(errCol), 1);

    // Reset while a host read is in RD_WAIT
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
    checkOutput("rrst addr", 32'(mAddrRd), 5);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 5, 0);
    checkOutput("rrst ack in rst", 32'(hostBus.ack), 0);
    idleCycle();
    checkOutput("rrst ack", 32'(hostBus.ack), 0);
    checkOutput("rrst rdata", 32'(hostBus.rdata), 0);
    checkOutput("rrst stall", 32'(coreStall), 0);
    checkOutput("rrst err_col", 32'(errCol), 0);
    idleCycle();
    checkOutput("rrst ack later", 32'(hostBus.ack), 0);
    hostRead(5, 16'h1234, "rrst rd5");
    idleCycle();

    // Back-to-back host reads over the whole memory
    for (int i = 0; i < MDATAS; i++) begin
      hostRead(i, expMem[i], $sformatf("sweep%0d", i));
    end
    idleCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChecks, numErrors);
    $finish;
  end

endmodule
